// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - state_t    : FSM state encodings (0..4 are legal, 5..7 are illegal)
//   - width_for  : counter width needed to hold values 0 .. max_count-1 (never 0)
//   - max3       : largest of three integers, used to size the shared timer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Width of a counter that must reach max_count-1. Minimum width is 1 bit.
    function automatic int width_for(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer that brings an asynchronous level into the
// clk domain. Both stages reset to 0.
// Ports:
//   clk      in   destination clock
//   reset_n  in   asynchronous active-low reset
//   d        in   asynchronous input (WIDTH bits)
//   q        out  synchronized output (WIDTH bits), two clk edges of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Drives the ADC clock PLL reset, qualifies its lock output, and holds the
// ADC/capture domain in reset until the PLL clocks have been stable long
// enough. Lock loss or lock timeout re-sequences the PLL; too many failed
// attempts park the block in FAULT until software requests a restart.
// Ports:
//   clk         in   50 MHz free-running reference clock
//   reset_n     in   asynchronous active-low reset
//   pll_locked  in   PLL lock indication, asynchronous to clk
//   restart     in   single-cycle software restart request
//   pll_rst     out  PLL reset, active high
//   dom_rst_n   out  ADC/capture domain reset, active low (high only in RUN)
//   ready       out  high only in RUN
//   fault       out  high only in FAULT
//   state       out  current state encoding
//   loss_count  out  saturating count of lock losses seen while in RUN
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             restart,
    output logic             pll_rst,
    output logic             dom_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] loss_count
);

    localparam int TMR_W = width_for(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
    localparam int RTY_W = width_for(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                lock_s;
    logic [2:0]          state_d, state_q;
    logic [TMR_W-1:0]    timer_d, timer_q;
    logic [RTY_W-1:0]    retry_d, retry_q;
    logic [CNT_W-1:0]    loss_d, loss_q;
    logic                pll_rst_d, pll_rst_q;
    logic                dom_rst_n_d, dom_rst_n_q;
    logic                ready_d, ready_q;
    logic                fault_d, fault_q;
    logic [RTY_W-1:0]    retry_inc;
    logic [2:0]          fail_state;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lock_s)
    );

    // Next-state, timer, retry and loss-counter logic. The timer is shared by
    // all timed states and restarts from 0 on every state entry. A failed
    // attempt (lock timeout or lock dropping during STABLE) goes to FAULT once
    // the incremented retry count reaches MAX_RETRIES. restart overrides
    // everything, including a lock loss in RUN, so loss_count is untouched.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        loss_d     = loss_q;
        retry_inc  = retry_q + RTY_ONE;
        fail_state = (retry_inc == RTY_MAX) ? ST_FAULT : ST_RESET_PLL;

        if (restart) begin
            state_d = ST_RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == TMO_LAST) begin
                        state_d = fail_state;
                        retry_d = retry_inc;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = fail_state;
                        retry_d = retry_inc;
                        timer_d = '0;
                    end else if (timer_q == STB_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                ST_RUN: begin
                    timer_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET_PLL;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + CNT_ONE;
                    end
                end
                ST_FAULT: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    always_comb begin
        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        dom_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RESET_PLL;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            dom_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            dom_rst_n_q <= dom_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign dom_rst_n  = dom_rst_n_q;
    assign ready      = ready_q;
    assign fault      = fault_q;
    assign state      = state_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Directed scenarios followed by a randomized phase, all compared each cycle
// against a behavioural model of the sequencer's rules, plus explicit latency
// and boundary checks.
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 3;
    localparam int CNT_W         = 2;
    localparam int LOSS_MAX      = (1 << CNT_W) - 1;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pll_locked;
    logic             restart;
    logic             pll_rst;
    logic             dom_rst_n;
    logic             ready;
    logic             fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] loss_count;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model: phase, cycles spent in it, failed attempts, losses,
    // and the two-edge delay history of pll_locked.
    int mPhase;
    int mElapsed;
    int mAttempts;
    int mLosses;
    bit mSync1;
    bit mSync2;

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .dom_rst_n  (dom_rst_n),
        .ready      (ready),
        .fault      (fault),
        .state      (state),
        .loss_count (loss_count)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase    = P_RESET;
        mElapsed  = 0;
        mAttempts = 0;
        mLosses   = 0;
        mSync1    = 1'b0;
        mSync2    = 1'b0;
    endtask

    task automatic enterPhase(input int p);
        mPhase   = p;
        mElapsed = 0;
    endtask

    task automatic attemptFailed();
        mAttempts++;
        enterPhase((mAttempts >= MAX_RETRIES) ? P_FAULT : P_RESET);
    endtask

    // Advance the model by one clock edge given the inputs present at it.
    task automatic modelEdge(input logic lk, input logic rs);
        bit lockS;
        if (!reset_n) begin
            modelReset();
            return;
        end
        lockS  = mSync2;
        mSync2 = mSync1;
        mSync1 = lk;
        if (rs) begin
            enterPhase(P_RESET);
            mAttempts = 0;
            return;
        end
        case (mPhase)
            P_RESET: begin
                mElapsed++;
                if (mElapsed == RST_CYCLES) enterPhase(P_WAIT);
            end
            P_WAIT: begin
                if (lockS) enterPhase(P_STABLE);
                else begin
                    mElapsed++;
                    if (mElapsed == LOCK_TIMEOUT) attemptFailed();
                end
            end
            P_STABLE: begin
                if (!lockS) attemptFailed();
                else begin
                    mElapsed++;
                    if (mElapsed == STABLE_CYCLES) begin
                        enterPhase(P_RUN);
                        mAttempts = 0;
                    end
                end
            end
            P_RUN: begin
                if (!lockS) begin
                    mLosses = (mLosses < LOSS_MAX) ? mLosses + 1 : LOSS_MAX;
                    enterPhase(P_RESET);
                end
            end
            default: ;
        endcase
    endtask

    task automatic checkAll();
        checkOutput("state",      32'(state),      32'(mPhase));
        checkOutput("pll_rst",    32'(pll_rst),    32'(mPhase == P_RESET || mPhase == P_FAULT));
        checkOutput("dom_rst_n",  32'(dom_rst_n),  32'(mPhase == P_RUN));
        checkOutput("ready",      32'(ready),      32'(mPhase == P_RUN));
        checkOutput("fault",      32'(fault),      32'(mPhase == P_FAULT));
        checkOutput("loss_count", 32'(loss_count), 32'(mLosses));
    endtask

    // One clock cycle: drive inputs, take the edge, compare against the model.
    task automatic applyStimulus(input logic lk, input logic rs);
        pll_locked = lk;
        restart    = rs;
        @(posedge clk);
        #1;
        modelEdge(lk, rs);
        checkAll();
        restart = 1'b0;
    endtask

    // Edges from state entry until pll_rst falls (lock held low).
    task automatic measurePllRst(output int n);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end while (pll_rst && n < 100);
    endtask

    // Raise lock; index of the edge (first edge = 0) at which dom_rst_n rises.
    task automatic waitRelease(output int n);
        n = 0;
        forever begin
            applyStimulus(1'b1, 1'b0);
            if (dom_rst_n || n >= 100) break;
            n++;
        end
    endtask

    // Drop lock; index of the edge at which dom_rst_n falls.
    task automatic waitLoss(output int n);
        n = 0;
        forever begin
            applyStimulus(1'b0, 1'b0);
            if (!dom_rst_n || n >= 100) break;
            n++;
        end
    endtask

    // Full bring-up from a fresh RESET_PLL entry with 3 idle cycles after pll_rst falls.
    task automatic bringUp(input string tag);
        int n;
        measurePllRst(n);
        checkOutput({tag, "_pll_rst_len"}, n, RST_CYCLES);
        repeat (3) applyStimulus(1'b0, 1'b0);
        waitRelease(n);
        checkOutput({tag, "_release_lat"}, n, STABLE_CYCLES + 2);
        checkOutput({tag, "_run_state"}, 32'(state), P_RUN);
    endtask

    // Watchdog so the bench cannot hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit sawRelease;
        int level;
        int runLen;

        reset_n    = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;
        modelReset();

        // Reset values while reset_n is low.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_pll_rst", 32'(pll_rst), 1);
        checkOutput("reset_state", 32'(state), P_RESET);
        reset_n = 1'b1;

        $display("[TB] normal bring-up");
        bringUp("bringup");

        $display("[TB] lock loss in RUN");
        waitLoss(n);
        checkOutput("loss_latency", n, 2);
        checkOutput("loss_pll_rst", 32'(pll_rst), 1);
        measurePllRst(n);
        checkOutput("loss_pll_rst_len", n, RST_CYCLES);
        repeat (3) applyStimulus(1'b0, 1'b0);
        waitRelease(n);
        checkOutput("loss_release_lat", n, STABLE_CYCLES + 2);
        checkOutput("loss_count_one", 32'(loss_count), 1);

        $display("[TB] restart vs lock loss");
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("restart_state", 32'(state), P_RESET);
        checkOutput("restart_loss_count", 32'(loss_count), 1);
        bringUp("restart");

        $display("[TB] timeout to fault");
        applyStimulus(1'b1, 1'b1);
        n = 0;
        do begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end while (!fault && n < 500);
        checkOutput("fault_edges", n, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
        repeat (30) applyStimulus(1'b0, 1'b0);
        checkOutput("fault_hold_state", 32'(state), P_FAULT);
        checkOutput("fault_hold_pll_rst", 32'(pll_rst), 1);

        $display("[TB] restart from fault, flaky lock");
        applyStimulus(1'b0, 1'b1);
        checkOutput("fault_restart_state", 32'(state), P_RESET);
        sawRelease = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n = 0;
            while (pll_rst && n < 50) begin
                applyStimulus(1'b0, 1'b0);
                n++;
            end
            repeat (2) applyStimulus(1'b0, 1'b0);
            repeat (5) begin
                applyStimulus(1'b1, 1'b0);
                if (dom_rst_n) sawRelease = 1'b1;
            end
            n = 0;
            do begin
                applyStimulus(1'b0, 1'b0);
                if (dom_rst_n) sawRelease = 1'b1;
                n++;
            end while (!pll_rst && n < 50);
        end
        checkOutput("flaky_fault", 32'(fault), 1);
        checkOutput("flaky_no_release", 32'(sawRelease), 0);

        $display("[TB] loss_count saturation");
        applyStimulus(1'b0, 1'b1);
        bringUp("sat_bringup");
        for (int i = 0; i < 4; i++) begin
            repeat (10) applyStimulus(1'b0, 1'b0);
            waitRelease(n);
        end
        checkOutput("loss_count_sat", 32'(loss_count), LOSS_MAX);

        $display("[TB] async reset mid-STABLE");
        repeat (10) applyStimulus(1'b0, 1'b0);
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end while (state != 3'(P_STABLE) && n < 50);
        repeat (2) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_reset_state", 32'(state), P_STABLE);
        #3;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        applyStimulus(1'b0, 1'b0);
        reset_n = 1'b1;
        bringUp("post_reset");

        $display("[TB] randomized phase");
        level  = 1;
        runLen = 0;
        for (int i = 0; i < 1500; i++) begin
            if (runLen == 0) begin
                level  = $urandom_range(0, 3) != 0 ? 1 : 0;
                runLen = $urandom_range(1, 30);
            end
            runLen--;
            applyStimulus(level[0], ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
